// File: rtl/tone_master_pkg.sv
// Shared types and constants for the tone pulse Avalon-MM master.
// The FSM state set and the registered bus command payload live here.
package tone_master_pkg;

    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned DUR_W_DEF  = 24;
    localparam int unsigned DATA_W     = 32;

    localparam logic [DATA_W-1:0] WR_ON_DATA  = 32'h1;
    localparam logic [DATA_W-1:0] WR_OFF_DATA = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ON   = 3'd1,
        ST_CHK_ON  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WR_OFF  = 3'd4,
        ST_CHK_OFF = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    // Registered request presented on the Avalon-MM master port.
    typedef struct packed {
        logic              chipselect;
        logic              write_n;
        logic [DATA_W-1:0] writedata;
    } avm_cmd_t;

    localparam avm_cmd_t AVM_CMD_IDLE = '{chipselect: 1'b0, write_n: 1'b1, writedata: WR_OFF_DATA};

endpackage

// File: rtl/tone_pulse_avalon_master_if.sv
// Avalon-MM bus between the tone pulse master and a single-bit PIO slave.
// Zero-latency reads; waitrequest stalls the current transfer.
interface tone_pulse_avalon_master_if
    import tone_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/tone_hold_counter.sv
// Loadable down-counter timing the HOLD phase of the tone pulse.
// Zero flag is registered alongside the count; the count never wraps below zero.
module tone_hold_counter
#(
    parameter int unsigned DUR_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DUR_W-1:0] load_val_i,
    output logic [DUR_W-1:0] count_o,
    output logic             zero_o
);

    logic [DUR_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !zero_q) begin
            count_d = count_q - DUR_W'(1);
        end
        zero_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/tone_pulse_avalon_master.sv
// Avalon-MM master that drives a PIO bit through one timed pulse:
// write 1, read back, hold for a programmed number of clocks, write 0, read back.
module tone_pulse_avalon_master
    import tone_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned TARGET_ADDR = 0,
    parameter int unsigned DUR_W       = DUR_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [DUR_W-1:0]             duration,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    tone_pulse_avalon_master_if.master   avm
);

    state_e            state_q, state_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    avm_cmd_t          cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              cnt_load;
    logic              cnt_en;
    logic [DUR_W-1:0]  cnt_val;
    logic              cnt_zero;
    logic              xfer_ok;
    logic              rd_bit;
    logic              unused_rdata;

    assign xfer_ok      = !avm.avm_waitrequest;
    assign rd_bit       = avm.avm_readdata[0];
    assign unused_rdata = ^avm.avm_readdata[DATA_W-1:1];

    tone_hold_counter #(
        .DUR_W (DUR_W)
    ) u_hold_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (dur_q),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Next state plus output decode; outputs follow the next state so they register in step with it.
    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cmd_d    = AVM_CMD_IDLE;
        addr_d   = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dur_d   = duration;
                    err_d   = 1'b0;
                    state_d = ST_WR_ON;
                end
            end
            ST_WR_ON: begin
                if (xfer_ok) begin
                    state_d = ST_CHK_ON;
                end
            end
            ST_CHK_ON: begin
                if (xfer_ok) begin
                    if (!rd_bit) begin
                        err_d = 1'b1;
                    end
                    if (dur_q == '0) begin
                        state_d = ST_WR_OFF;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Count holds D..1 across the D hold cycles; leave on the last one.
                cnt_en = !cnt_zero;
                if (abort || (cnt_val == DUR_W'(1))) begin
                    state_d = ST_WR_OFF;
                end
            end
            ST_WR_OFF: begin
                if (xfer_ok) begin
                    state_d = ST_CHK_OFF;
                end
            end
            ST_CHK_OFF: begin
                if (xfer_ok) begin
                    if (rd_bit) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_WR_ON:   cmd_d = '{chipselect: 1'b1, write_n: 1'b0, writedata: WR_ON_DATA};
            ST_WR_OFF:  cmd_d = '{chipselect: 1'b1, write_n: 1'b0, writedata: WR_OFF_DATA};
            ST_CHK_ON,
            ST_CHK_OFF: cmd_d = '{chipselect: 1'b1, write_n: 1'b1, writedata: WR_OFF_DATA};
            default:    cmd_d = AVM_CMD_IDLE;
        endcase

        if (cmd_d.chipselect) begin
            addr_d = ADDR_W'(TARGET_ADDR);
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            cmd_q   <= AVM_CMD_IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cmd_q.chipselect;
    assign avm.avm_write_n    = cmd_q.write_n;
    assign avm.avm_writedata  = cmd_q.writedata;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = err_q;

endmodule

// File: tb/tb_tone_pulse_avalon_master.sv
// Bench for tone_pulse_avalon_master: PIO slave model with stall/readback injection,
// transaction-level expectations queued at issue time and checked by a monitor.
module tb_tone_pulse_avalon_master;
    import tone_master_pkg::*;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned TGT    = 2;
    localparam int unsigned DUR_W  = 24;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [DUR_W-1:0] duration;
    logic             busy;
    logic             done;
    logic             error;

    tone_pulse_avalon_master_if #(.ADDR_W(ADDR_W)) bus ();

    tone_pulse_avalon_master #(
        .ADDR_W      (ADDR_W),
        .TARGET_ADDR (TGT),
        .DUR_W       (DUR_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .duration (duration),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .avm      (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        int cyc;
        bit err;
    } done_t;

    xfer_t xfer_q[$];
    done_t done_q[$];
    int    hi_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected-behaviour windows of the sequence currently in flight.
    int start_cyc = -100;
    int busy_end  = -1;
    bit seq_err   = 1'b0;

    int       stall_plan [4];
    bit [3:0] flip_plan = '0;

    logic        out_port = 1'b0;
    logic        last_wd  = 1'b0;
    logic [31:0] noise    = '0;
    logic        rd_flip;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // PIO slave register
    always @(posedge clk) begin
        if (bus.avm_chipselect && !bus.avm_waitrequest && !bus.avm_write_n) begin
            out_port <= bus.avm_writedata[0];
            last_wd  <= bus.avm_writedata[0];
        end
    end

    function automatic int cur_idx();
        if (!bus.avm_write_n) return bus.avm_writedata[0] ? 0 : 2;
        return last_wd ? 1 : 3;
    endfunction

    assign rd_flip = (bus.avm_chipselect && bus.avm_write_n) ? flip_plan[cur_idx()] : 1'b0;
    assign bus.avm_readdata = bus.avm_waitrequest ? noise : {noise[31:1], out_port ^ rd_flip};

    // Stall injection and monitor, both on the falling edge.
    always @(negedge clk) begin : mon
        int          stall_ctr;
        bit          held_v;
        logic [34:0] held;
        logic [34:0] cur;
        bit          prev_out;
        int          hi_len;
        xfer_t       x;
        done_t       dn;
        int          h;

        noise = $urandom;
        if (bus.avm_chipselect && stall_ctr < stall_plan[cur_idx()]) begin
            bus.avm_waitrequest = 1'b1;
            stall_ctr++;
        end else begin
            bus.avm_waitrequest = 1'b0;
            stall_ctr = 0;
        end

        check("busy", 32'(busy), 32'((cyc > start_cyc) && (cyc <= busy_end)));
        if (cyc == start_cyc + 1) check("error_cleared", 32'(error), 32'd0);
        if (cyc > busy_end) check("error_sticky", 32'(error), 32'(seq_err));
        if (!bus.avm_chipselect) check("addr_idle", 32'(bus.avm_address), 32'd0);
        if (!bus.avm_chipselect || bus.avm_write_n) check("wdata_not_write", bus.avm_writedata, 32'd0);

        cur = {bus.avm_address, bus.avm_write_n, bus.avm_writedata};
        if (bus.avm_chipselect) begin
            if (held_v) check("stall_stable", 32'(cur != held), 32'd0);
            held_v = bus.avm_waitrequest;
            held   = cur;
        end else begin
            held_v = 1'b0;
        end

        if (out_port) begin
            hi_len++;
        end else if (prev_out) begin
            if (hi_q.size() == 0) begin
                check("out_port_unexpected_fall", 32'd1, 32'd0);
            end else begin
                h = hi_q.pop_front();
                check("out_port_high_len", 32'(hi_len), 32'(h));
            end
        end
        prev_out = out_port;

        if (bus.avm_chipselect && !bus.avm_waitrequest) begin
            if (xfer_q.size() == 0) begin
                check("xfer_unexpected", 32'd1, 32'd0);
            end else begin
                x = xfer_q.pop_front();
                check("xfer_dir", 32'(bus.avm_write_n), 32'(!x.wr));
                check("xfer_addr", 32'(bus.avm_address), 32'(TGT));
                if (x.wr) check("xfer_wdata", bus.avm_writedata, x.data);
                if (x.wr && x.data == 32'd1) hi_len = 0;
            end
        end

        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                dn = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(dn.cyc));
                check("done_error", 32'(error), 32'(dn.err));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One start request; latency = 5 + effective hold + all stall cycles.
    task automatic issue(input int d, input int s0, input int s1, input int s2, input int s3,
                         input bit f_on, input bit f_off, input int ab, input bit spur);
        int c, deff, lat, hs;
        xfer_t x;
        done_t dn;
        tick();
        c = cyc;
        stall_plan[0] = s0; stall_plan[1] = s1; stall_plan[2] = s2; stall_plan[3] = s3;
        flip_plan = {f_off, 1'b0, f_on, 1'b0};
        deff = (ab > 0 && ab <= d) ? ab : d;
        lat  = 5 + deff + s0 + s1 + s2 + s3;
        hs   = c + 3 + s0 + s1;
        x.wr = 1'b1; x.data = WR_ON_DATA;  xfer_q.push_back(x);
        x.wr = 1'b0; x.data = '0;          xfer_q.push_back(x);
        x.wr = 1'b1; x.data = WR_OFF_DATA; xfer_q.push_back(x);
        x.wr = 1'b0; x.data = '0;          xfer_q.push_back(x);
        dn.cyc = c + lat; dn.err = f_on | f_off; done_q.push_back(dn);
        hi_q.push_back(deff + 2 + s1 + s2);
        start_cyc = c;
        busy_end  = c + lat;
        seq_err   = f_on | f_off;
        start     = 1'b1;
        duration  = DUR_W'(d);
        tick();
        start    = 1'b0;
        duration = DUR_W'($urandom);
        while (cyc < c + lat) begin
            tick();
            start = spur && (cyc == hs || cyc == c + lat);
            abort = (ab > 0) && (cyc == hs + ab - 1);
        end
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Reset asserted in the second HOLD cycle of a long pulse.
    task automatic reset_in_hold(input int d);
        int c;
        xfer_t x;
        tick();
        c = cyc;
        stall_plan = '{0, 0, 0, 0};
        flip_plan  = '0;
        x.wr = 1'b1; x.data = WR_ON_DATA; xfer_q.push_back(x);
        x.wr = 1'b0; x.data = '0;         xfer_q.push_back(x);
        start_cyc = c;
        busy_end  = c + 1000;
        seq_err   = 1'b0;
        start     = 1'b1;
        duration  = DUR_W'(d);
        tick();
        start = 1'b0;
        while (cyc < c + 4) tick();
        reset_n  = 1'b0;
        busy_end = c + 4;
        tick();
        check("reset_cs", 32'(bus.avm_chipselect), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int d, ab;
        int s [4];
        bit f_on, f_off, spur;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        duration = '0;
        stall_plan = '{0, 0, 0, 0};
        bus.avm_waitrequest = 1'b0;
        repeat (3) tick();
        check("reset_cs", 32'(bus.avm_chipselect), 32'd0);
        check("reset_write_n", 32'(bus.avm_write_n), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        issue(5, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        issue(5, 3, 0, 0, 2, 1'b0, 1'b0, 0, 1'b0);
        issue(0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        issue(4, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        repeat (3) tick();
        issue(3, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        issue(100, 0, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0);
        issue(6, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        reset_in_hold(30);
        issue(2, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int k = 0; k < 4; k++) s[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : 0;
            ab    = (d > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, d)) : 0;
            f_on  = ($urandom_range(0, 4) == 0);
            f_off = ($urandom_range(0, 4) == 0);
            spur  = ($urandom_range(0, 1) == 1);
            issue(d, s[0], s[1], s[2], s[3], f_on, f_off, ab, spur);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (20) tick();
        check("xfer_q_drained", 32'(xfer_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        check("hi_q_drained", 32'(hi_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
